set_assoc_cache: RTL
====================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameter WAYS, 4, associativity; power of two, 2..8.
REQ-002 Parameter SET_BITS, 6, set index width; sets = 2**SET_BITS.
REQ-003 Parameter ADDR_W, 32, byte address width; addr[1:0] word offset, addr[SET_BITS+1:2] set, remainder tag.
REQ-004 Parameter DATA_W, 32, word width; one word per line.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 cpu_req / cpu_we  in  1 / 1  request valid; 1 = write, 0 = read.
REQ-009 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  request address, write data.
REQ-010 cpu_ready  out  1  one-cycle completion pulse.
REQ-011 cpu_rdata / cpu_hit  out  DATA_W / 1  read data and hit flag, valid only with cpu_ready.
REQ-012 mem_req / mem_we  out  1 / 1  backing-memory request valid; 1 = write.
REQ-013 mem_addr / mem_wdata  out  ADDR_W / DATA_W  backing-memory address, write data.
REQ-014 mem_ack / mem_rdata  in  1 / DATA_W  memory completion, read data valid with mem_ack.
REQ-015 flush  in  1  invalidate-all request; flush_busy  out  1  high while invalidating.

Function
REQ-016 FSM states IDLE, LOOKUP, MISS, WRITE, FLUSH.
REQ-017 IDLE: flush=1 -> FLUSH (priority over cpu_req); else cpu_req=1 -> capture addr/wdata/we, go LOOKUP.
REQ-018 LOOKUP read hit: cpu_ready=1, cpu_hit=1, cpu_rdata=hit way data, LRU update, -> IDLE (accept-to-ready 1 cycle).
REQ-019 LOOKUP read miss -> MISS; MISS: mem_req=1, mem_we=0, mem_addr=captured addr held until mem_ack.
REQ-020 MISS on mem_ack: fill victim way (tag, valid=1, data=mem_rdata), LRU update on that way, cpu_ready=1, cpu_hit=0, cpu_rdata=mem_rdata, -> IDLE.
REQ-021 LOOKUP write: on hit update hit way data and LRU in that cycle; miss does not allocate; -> WRITE.
REQ-022 WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata captured, held until mem_ack; then cpu_ready=1, cpu_hit=lookup result, -> IDLE (write-through).
REQ-023 Victim: lowest-index invalid way; if none, way whose age = WAYS-1.
REQ-024 LRU: per-set age of log2(WAYS) bits per way; accessed way -> 0; ways with age < old accessed age increment; others hold; ages stay a permutation of 0..WAYS-1.
REQ-025 FLUSH: clear valid of all ways of one set per cycle, set counter 0..2**SET_BITS-1, flush_busy=1 throughout, -> IDLE after last set; ages untouched; cpu_req not accepted.
REQ-026 mem_ack outside MISS/WRITE ignored; cpu_req outside IDLE ignored; flush outside IDLE ignored (not queued).
REQ-027 Requester holds cpu_req and inputs until cpu_ready; block uses only captured values after acceptance.
REQ-028 Tag compare requires valid=1; at most one way hits (fill never duplicates a tag).

Reset
REQ-029 rst_n low: state IDLE, all valid bits 0, ages of way i = i in every set, flush counter 0, cpu_ready/cpu_hit/mem_req/mem_we/flush_busy 0, cpu_rdata 0.
REQ-030 Reset mid-MISS/WRITE/FLUSH aborts immediately; mem_req drops asynchronously; no fill occurs.
REQ-031 Tag and data arrays are not reset.

Structure
REQ-032 Package cache_pkg holds the FSM state enum and derived widths (tag width, age width) as functions of parameters.
REQ-033 Sub-module cache_lru: per-set age storage, victim select and age update; top holds FSM, tag/valid/data arrays.

Verification (WAYS=4, SET_BITS=6)
REQ-034 Cold read 0x100 -> mem_req read 0x100; ack with 0xDEADBEEF -> cpu_ready, hit=0, rdata 0xDEADBEEF; re-read -> ready 1 cycle after accept, hit=1, no mem_req.
REQ-035 Reads 0x000,0x100,0x200,0x300, read 0x000 (hit), read 0x400 -> evicts 0x100's way; then 0x100 misses, 0x000 hits.
REQ-036 Write 0x100 data 0x1234 after fill -> mem write 0x100/0x1234, hit=1, later read hits 0x1234; write 0x800 cold -> mem write, hit=0, later read 0x800 misses.
REQ-037 flush and cpu_req same IDLE cycle -> flush_busy 64 cycles, request then accepted; all prior lines miss.
REQ-038 mem_ack delayed 10 cycles in MISS -> mem_req/mem_addr stable, cpu_ready low until ack cycle.
REQ-039 rst_n low during MISS -> mem_req 0 immediately; after release, read of previously cached 0x000 misses.

Source files
------------

// File: rtl/set_assoc_cache_pkg.sv
// Shared definitions for the set-associative cache.
//   state_t      : controller FSM states
//   age_width()  : bits per LRU age / way index, log2(ways)
//   tag_width()  : tag bits left after word offset and set index
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MISS   = 3'd2,
        WRITE  = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    function automatic int age_width(input int ways);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < ways) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int tag_width(input int addr_w, input int set_bits);
        return addr_w - set_bits - 2;
    endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// Bus bundle between a requester, the cache and the backing memory.
// Handshake semantics: a request (cpu_req / mem_req) is raised by its
// initiator and held, with all its qualifiers stable, until the responder
// pulses the matching completion (cpu_ready / mem_ack) for exactly one cycle;
// completion data (cpu_rdata, cpu_hit, mem_rdata) is valid only in that cycle.
//   slave  : cache side  (receives cpu_*, drives mem_*, serves flush)
//   master : requester / memory model side
interface set_assoc_cache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_hit;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              flush;
    logic              flush_busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata, flush,
        output cpu_ready, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               flush_busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata, flush,
        input  cpu_ready, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               flush_busy
    );
endinterface

// File: rtl/set_assoc_cache_lru.sv
// Per-set LRU ages and victim selection.
//   clk, rst_n  : clock, asynchronous active-low reset (ages of way i = i)
//   i_set       : set being looked up / updated
//   i_valid     : valid bits of that set's ways
//   i_upd       : mark i_upd_way as most recently used in i_set
//   i_upd_way   : way being accessed
//   o_victim    : lowest-index invalid way, else the way with the oldest age
module cache_lru
    import cache_pkg::*;
#(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 6,
    localparam int AGE_W   = age_width(WAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SET_BITS-1:0] i_set,
    input  logic [WAYS-1:0]     i_valid,
    input  logic                i_upd,
    input  logic [AGE_W-1:0]    i_upd_way,
    output logic [AGE_W-1:0]    o_victim
);
    localparam int SETS = 2 ** SET_BITS;

    logic [AGE_W-1:0] r_age [SETS][WAYS];
    logic [AGE_W-1:0] w_acc_age;
    logic [AGE_W-1:0] w_oldest;
    logic [AGE_W-1:0] w_first_inv;
    logic             w_inv_found;

    assign w_acc_age = r_age[i_set][i_upd_way];

    // Scan downward so the last assignment leaves the lowest invalid index.
    always_comb begin
        w_oldest    = '0;
        w_first_inv = '0;
        w_inv_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_age[i_set][w] == AGE_W'(WAYS - 1)) begin
                w_oldest = AGE_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                w_inv_found = 1'b1;
                w_first_inv = AGE_W'(w);
            end
        end
        o_victim = w_inv_found ? w_first_inv : w_oldest;
    end

    // Accessed way becomes youngest; only ways younger than it age by one,
    // which keeps each set's ages a permutation of 0..WAYS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= AGE_W'(w);
                end
            end
        end else if (i_upd) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w == int'(i_upd_way)) begin
                    r_age[i_set][w] <= '0;
                end else if (r_age[i_set][w] < w_acc_age) begin
                    r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-through, no-write-allocate set-associative cache, one word per line.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : cpu request/completion, backing-memory request/ack, flush
//   o_dbg_state  : current controller state
// Reads hit in one cycle after acceptance; read misses fetch from memory and
// fill the victim way; writes always go to memory and update a hitting line.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 6,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    set_assoc_cache_if.slave   bus,
    output state_t             o_dbg_state
);
    localparam int SETS  = 2 ** SET_BITS;
    localparam int AGE_W = age_width(WAYS);
    localparam int TAG_W = tag_width(ADDR_W, SET_BITS);

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic                r_wr_hit;
    logic [SET_BITS-1:0] r_flush_cnt;

    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];

    logic [SET_BITS-1:0] w_set;
    logic [TAG_W-1:0]    w_tag;
    logic [WAYS-1:0]     w_set_valid;
    logic [WAYS-1:0]     w_hit_vec;
    logic                w_hit;
    logic [AGE_W-1:0]    w_hit_way;
    logic [AGE_W-1:0]    w_victim;
    logic                w_fill;
    logic                w_lru_upd;
    logic [AGE_W-1:0]    w_lru_way;

    logic                w_cpu_ready;
    logic                w_cpu_hit;
    logic [DATA_W-1:0]   w_cpu_rdata;
    logic                w_mem_req;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic                w_flush_busy;

    // Everything after acceptance works from the captured request.
    assign w_set       = r_addr[SET_BITS+1:2];
    assign w_tag       = r_addr[ADDR_W-1:SET_BITS+2];
    assign w_set_valid = r_valid[w_set];

    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_set_valid[w] && (r_tag[w_set][w] == w_tag)) begin
                w_hit_vec[w] = 1'b1;
                w_hit_way    = AGE_W'(w);
            end
        end
    end
    assign w_hit = |w_hit_vec;

    assign w_fill    = (r_state == MISS) && bus.mem_ack;
    assign w_lru_upd = w_fill || ((r_state == LOOKUP) && w_hit);
    assign w_lru_way = w_fill ? w_victim : w_hit_way;

    cache_lru #(
        .WAYS     (WAYS),
        .SET_BITS (SET_BITS)
    ) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set     (w_set),
        .i_valid   (w_set_valid),
        .i_upd     (w_lru_upd),
        .i_upd_way (w_lru_way),
        .o_victim  (w_victim)
    );

    // Outputs are decoded from state, so reset clears them asynchronously.
    always_comb begin
        w_next_state = r_state;
        w_cpu_ready  = 1'b0;
        w_cpu_hit    = 1'b0;
        w_cpu_rdata  = '0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_flush_busy = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.flush) begin
                    w_next_state = FLUSH;
                end else if (bus.cpu_req) begin
                    w_next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (r_we) begin
                    w_next_state = WRITE;
                end else if (w_hit) begin
                    w_cpu_ready  = 1'b1;
                    w_cpu_hit    = 1'b1;
                    w_cpu_rdata  = r_data[w_set][w_hit_way];
                    w_next_state = IDLE;
                end else begin
                    w_next_state = MISS;
                end
            end
            MISS: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_addr;
                if (bus.mem_ack) begin
                    w_cpu_ready  = 1'b1;
                    w_cpu_rdata  = bus.mem_rdata;
                    w_next_state = IDLE;
                end
            end
            WRITE: begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = r_addr;
                w_mem_wdata = r_wdata;
                if (bus.mem_ack) begin
                    w_cpu_ready  = 1'b1;
                    w_cpu_hit    = r_wr_hit;
                    w_next_state = IDLE;
                end
            end
            FLUSH: begin
                w_flush_busy = 1'b1;
                if (r_flush_cnt == SET_BITS'(SETS - 1)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_wr_hit    <= 1'b0;
            r_flush_cnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && !bus.flush && bus.cpu_req) begin
                r_addr  <= bus.cpu_addr;
                r_wdata <= bus.cpu_wdata;
                r_we    <= bus.cpu_we;
            end
            if (r_state == LOOKUP) begin
                r_wr_hit <= w_hit;
            end
            // Counter wraps back to 0 on the last set, ready for the next flush.
            if (r_state == FLUSH) begin
                r_valid[r_flush_cnt] <= '0;
                r_flush_cnt          <= r_flush_cnt + 1'b1;
            end
            if (w_fill) begin
                r_valid[w_set][w_victim] <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; valid bits guard every use of it.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_set][w_victim]  <= w_tag;
            r_data[w_set][w_victim] <= bus.mem_rdata;
        end
        if ((r_state == LOOKUP) && r_we && w_hit) begin
            r_data[w_set][w_hit_way] <= r_wdata;
        end
    end

    assign bus.cpu_ready  = w_cpu_ready;
    assign bus.cpu_hit    = w_cpu_hit;
    assign bus.cpu_rdata  = w_cpu_rdata;
    assign bus.mem_req    = w_mem_req;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.flush_busy = w_flush_busy;
    assign o_dbg_state    = r_state;

endmodule
